io_seg7_scan: RTL and testbench

- Downstream consumer of the data-memory I/O output port `out_port0`, which is written via the addr[7] I/O space.
- Latches the 32-bit port value on a write strobe.
- Drives an 8-digit multiplexed, common-anode seven-segment display in hexadecimal.
- Provides tear-free frame updates, leading-zero blanking and anti-ghosting blank time.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/hex7seg.sv | 13 +
 rtl/io_seg7_scan.sv | 114 +++++++++++
 tb/tb_io_seg7_scan.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: digit count,
// active-low "all off" codes and the hex-to-segment lookup table.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int NIBBLE_W   = 4;
  localparam int SEG_W      = 7;
  localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;

  // Active-low g..a patterns; entry n is the glyph for hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Pure combinational hex nibble to active-low seven-segment decode (g..a).
module hex7seg
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] hex,
  output logic [SEG_W-1:0]    seg_n
);

  always_comb begin
    seg_n = hex_to_seg(hex);
  end

endmodule

// File: rtl/io_seg7_scan.sv
// Multiplexed 8-digit common-anode hex display fed from an I/O output port,
// with frame-synchronous updates, leading-zero blanking and ghost blanking.
module io_seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int GHOST_CYCLES  = 500,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  update,
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]      SCAN_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]      GHOST_LIM  = PW'(GHOST_CYCLES);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler_reg;
  logic [DIGIT_W-1:0]      index_reg;
  logic [VALUE_W-1:0]      shadow_reg;
  logic [VALUE_W-1:0]      display_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic [SEG_W-1:0]        seg_reg;
  logic                    frame_reg;

  logic [PW-1:0]           prescaler_next;
  logic [DIGIT_W-1:0]      index_next;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [SEG_W-1:0]        seg_next;

  logic                    tick;
  logic                    wrap;
  logic                    ghost;
  logic                    dark;
  logic [NIBBLE_W-1:0]     nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   digit_blank;
  logic [NIBBLE_W-1:0]     cur_nibble;
  logic [SEG_W-1:0]        dec_seg;

  assign tick = (prescaler_reg == SCAN_LAST);
  assign wrap = tick && (index_reg == LAST_DIGIT);

  // A digit is blanked when it and every more-significant nibble are zero;
  // digit 0 always shows so a zero value still reads "0".
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nibble[gi] = display_reg[gi*NIBBLE_W +: NIBBLE_W];
    if (gi == 0 || BLANK_LEADING == 0) begin : g_keep
      assign digit_blank[gi] = 1'b0;
    end else begin : g_blank
      assign digit_blank[gi] = ~|display_reg[VALUE_W-1:gi*NIBBLE_W];
    end
  end

  assign cur_nibble = nibble[index_reg];

  hex7seg u_hex7seg (
    .hex   (cur_nibble),
    .seg_n (dec_seg)
  );

  always_comb begin
    prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
    index_next     = tick ? index_reg + 1'b1 : index_reg;
  end

  // Outputs are computed from the current scan state and registered, so
  // anodes and segments change together one cycle behind the counters.
  always_comb begin
    ghost    = (prescaler_reg < GHOST_LIM);
    dark     = ghost || digit_blank[index_reg];
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    if (!dark) begin
      an_next  = ~(NUM_DIGITS'(1) << index_reg);
      seg_next = dec_seg;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prescaler_reg <= '0;
      index_reg     <= '0;
      shadow_reg    <= '0;
      display_reg   <= '0;
      an_reg        <= AN_OFF;
      seg_reg       <= SEG_OFF;
      frame_reg     <= 1'b0;
    end else begin
      prescaler_reg <= prescaler_next;
      index_reg     <= index_next;
      if (update) begin
        shadow_reg <= value;
      end
      // Non-blocking read of shadow_reg means a coincident update lands next frame.
      if (wrap) begin
        display_reg <= shadow_reg;
      end
      an_reg    <= an_next;
      seg_reg   <= seg_next;
      frame_reg <= wrap;
    end
  end

  assign an_n  = an_reg;
  assign seg_n = seg_reg;
  assign frame = frame_reg;

endmodule

// File: tb/tb_io_seg7_scan.sv
// Randomized and directed bench for io_seg7_scan against a cycle-count based
// reference model (slot = cycle/4, digit = slot mod 8, frame = 32 cycles).
module tb_io_seg7_scan;

  localparam int SD = 4;
  localparam int GC = 1;
  localparam int FRAME_LEN = SD * 8;

  logic        clk;
  logic        resetn;
  logic [31:0] value;
  logic        update;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic        frame;

  int total;
  int bad;

  int          m_cnt;
  logic [31:0] m_shadow;
  logic [31:0] m_disp;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_frame;

  logic [6:0] ref_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  io_seg7_scan #(
    .SCAN_DIV      (SD),
    .GHOST_CYCLES  (GC),
    .BLANK_LEADING (1)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .value  (value),
    .update (update),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: drive inputs, advance the model, leave outputs settled.
  task automatic cyc(input logic upd, input logic [31:0] val);
    int p;
    int d;
    logic [31:0] upper;
    logic [3:0]  nib;
    update = upd;
    value  = val;
    @(posedge clk);
    p     = m_cnt % SD;
    d     = (m_cnt / SD) % 8;
    upper = m_disp >> (4 * d);
    nib   = upper[3:0];
    if (p < GC || (d > 0 && upper == 32'h0)) begin
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      exp_an  = ~(8'h01 << d);
      exp_seg = ref_tbl[nib];
    end
    exp_frame = (m_cnt % FRAME_LEN == FRAME_LEN - 1);
    if (exp_frame) m_disp = m_shadow;
    if (upd) m_shadow = val;
    m_cnt++;
    #1;
    update = 1'b0;
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_shadow = 32'h0;
    m_disp   = 32'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    update = 1'b0;
    value  = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total += 3;
    if (an_n !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h exp=ff", an_n); end
    if (seg_n !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg_n); end
    if (frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b exp=0", frame); end
    resetn = 1'b1;
    $display("test_reset: outputs off while held");
  endtask

  task automatic test_idle();
    int frames = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 32'h0);
      if (frame === 1'b1) frames++;
      total += 3;
      if (an_n !== exp_an) begin bad++; $display("FAIL idle_an c=%0d got=%h exp=%h", c, an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL idle_seg c=%0d got=%b exp=%b", c, seg_n, exp_seg); end
      if (frame !== exp_frame) begin bad++; $display("FAIL idle_frame c=%0d got=%b exp=%b", c, frame, exp_frame); end
    end
    total++;
    if (frames != 1) begin bad++; $display("FAIL idle_frame_count got=%0d exp=1", frames); end
    $display("test_idle: 40 cycles, frames=%0d", frames);
  endtask

  task automatic test_pattern();
    int seen7 = 0;
    cyc(1'b1, 32'h12345678);
    for (int c = 0; c < 70; c++) begin
      cyc(1'b0, 32'h0);
      if (an_n === 8'h7F && seg_n === 7'b1111001) seen7++;
      total += 3;
      if (an_n !== exp_an) begin bad++; $display("FAIL pattern_an c=%0d got=%h exp=%h", c, an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL pattern_seg c=%0d got=%b exp=%b", c, seg_n, exp_seg); end
      if (frame !== exp_frame) begin bad++; $display("FAIL pattern_frame c=%0d got=%b exp=%b", c, frame, exp_frame); end
    end
    total++;
    if (seen7 == 0) begin bad++; $display("FAIL pattern_digit7 got=%0d exp>0", seen7); end
    $display("test_pattern: 12345678, digit7 lit %0d cycles", seen7);
  endtask

  task automatic test_blanking();
    int lit_high = 0;
    cyc(1'b1, 32'h000000A5);
    while (m_cnt % FRAME_LEN != 1) begin
      cyc(1'b0, 32'h0);
      total += 2;
      if (an_n !== exp_an) begin bad++; $display("FAIL blank_pre_an got=%h exp=%h", an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL blank_pre_seg got=%b exp=%b", seg_n, exp_seg); end
    end
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 32'h0);
      if (an_n[7:2] !== 6'h3F) lit_high++;
      total += 3;
      if (an_n !== exp_an) begin bad++; $display("FAIL blank_an c=%0d got=%h exp=%h", c, an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL blank_seg c=%0d got=%b exp=%b", c, seg_n, exp_seg); end
      if (frame !== exp_frame) begin bad++; $display("FAIL blank_frame c=%0d got=%b exp=%b", c, frame, exp_frame); end
    end
    total++;
    if (lit_high != 0) begin bad++; $display("FAIL blank_high_digits got=%0d exp=0", lit_high); end
    $display("test_blanking: 000000A5, high digits lit %0d cycles", lit_high);
  endtask

  task automatic test_last_wins();
    int lit_high = 0;
    while (m_cnt % FRAME_LEN != 10) cyc(1'b0, 32'h0);
    cyc(1'b1, 32'hDEADBEEF);
    cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h00000001);
    while (m_cnt % FRAME_LEN != 1) begin
      cyc(1'b0, 32'h0);
      total += 2;
      if (an_n !== exp_an) begin bad++; $display("FAIL last_pre_an got=%h exp=%h", an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL last_pre_seg got=%b exp=%b", seg_n, exp_seg); end
    end
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 32'h0);
      if (an_n[7:1] !== 7'h7F) lit_high++;
      total += 2;
      if (an_n !== exp_an) begin bad++; $display("FAIL last_an c=%0d got=%h exp=%h", c, an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL last_seg c=%0d got=%b exp=%b", c, seg_n, exp_seg); end
    end
    total++;
    if (lit_high != 0) begin bad++; $display("FAIL last_wins_high got=%0d exp=0", lit_high); end
    $display("test_last_wins: DEADBEEF then 00000001 in one frame");
  endtask

  task automatic test_wrap_coincide();
    int old_seen = 0;
    int new_seen = 0;
    cyc(1'b1, 32'h00000042);
    while (m_cnt % FRAME_LEN != FRAME_LEN - 1) cyc(1'b0, 32'h0);
    repeat (FRAME_LEN) cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h00000099);
    for (int c = 0; c < 2 * FRAME_LEN; c++) begin
      cyc(1'b0, 32'h0);
      if (c < FRAME_LEN && an_n === 8'hFD && seg_n === 7'b0011001) old_seen++;
      if (c >= FRAME_LEN && an_n === 8'hFD && seg_n === 7'b0010000) new_seen++;
      total += 3;
      if (an_n !== exp_an) begin bad++; $display("FAIL wrap_an c=%0d got=%h exp=%h", c, an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL wrap_seg c=%0d got=%b exp=%b", c, seg_n, exp_seg); end
      if (frame !== exp_frame) begin bad++; $display("FAIL wrap_frame c=%0d got=%b exp=%b", c, frame, exp_frame); end
    end
    total += 2;
    if (old_seen == 0) begin bad++; $display("FAIL wrap_old_kept got=%0d exp>0", old_seen); end
    if (new_seen == 0) begin bad++; $display("FAIL wrap_new_next got=%0d exp>0", new_seen); end
    $display("test_wrap_coincide: old=%0d new=%0d cycles", old_seen, new_seen);
  endtask

  task automatic test_async_reset();
    int zero_seen = 0;
    cyc(1'b1, 32'hFFFFFFFF);
    repeat (40) cyc(1'b0, 32'h0);
    while (m_cnt % SD != 2) cyc(1'b0, 32'h0);
    total++;
    if (an_n === 8'hFF) begin bad++; $display("FAIL async_pre_lit got=%h exp=lit digit", an_n); end
    #1;
    resetn = 1'b0;
    #1;
    total += 3;
    if (an_n !== 8'hFF) begin bad++; $display("FAIL async_an got=%h exp=ff", an_n); end
    if (seg_n !== 7'h7F) begin bad++; $display("FAIL async_seg got=%h exp=7f", seg_n); end
    if (frame !== 1'b0) begin bad++; $display("FAIL async_frame got=%b exp=0", frame); end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 32'h0);
      if (an_n === 8'hFE && seg_n === 7'b1000000) zero_seen++;
      total += 3;
      if (an_n !== exp_an) begin bad++; $display("FAIL arst_an c=%0d got=%h exp=%h", c, an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL arst_seg c=%0d got=%b exp=%b", c, seg_n, exp_seg); end
      if (frame !== exp_frame) begin bad++; $display("FAIL arst_frame c=%0d got=%b exp=%b", c, frame, exp_frame); end
    end
    total++;
    if (zero_seen == 0) begin bad++; $display("FAIL arst_zero_digit got=%0d exp>0", zero_seen); end
    $display("test_async_reset: zero shown %0d cycles after release", zero_seen);
  endtask

  task automatic test_random();
    logic        upd;
    logic [31:0] val;
    int          ups = 0;
    for (int c = 0; c < 400; c++) begin
      upd = ($urandom_range(0, 11) == 0);
      val = $urandom >> $urandom_range(0, 31);
      if (upd) ups++;
      cyc(upd, val);
      total += 3;
      if (an_n !== exp_an) begin bad++; $display("FAIL rand_an c=%0d got=%h exp=%h", c, an_n, exp_an); end
      if (seg_n !== exp_seg) begin bad++; $display("FAIL rand_seg c=%0d got=%b exp=%b", c, seg_n, exp_seg); end
      if (frame !== exp_frame) begin bad++; $display("FAIL rand_frame c=%0d got=%b exp=%b", c, frame, exp_frame); end
    end
    $display("test_random: 400 cycles, %0d updates", ups);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    update = 1'b0;
    value  = 32'h0;
    test_reset();
    test_idle();
    test_pattern();
    test_blanking();
    test_last_wins();
    test_wrap_coincide();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
